// File: rtl/gray_decoder.sv
// Receive-side Gray-code decoder: converts sampled Gray counts to binary, checks
// that each accepted sample is a single forward step, and reports steps, wraps and faults.
module gray_decoder #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Gray_In,
    output logic [WIDTH-1:0] Binary,
    output logic             Step,
    output logic             Wrap,
    output logic             Step_Err,
    output logic             Overflow,
    output logic             Locked,
    output logic [ERRW-1:0]  Err_Count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_STEP = WIDTH'(1);

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] ref_r;
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] delta_s;
    logic             ref_max_s;
    logic             err_max_s;

    // Decode the incoming sample and measure its distance from the reference.
    always_comb begin
        bin_s     = gray_to_bin(Gray_In);
        delta_s   = bin_s - ref_r;
        ref_max_s = &ref_r;
        err_max_s = &Err_Count;
    end

    // Tracking state machine with all outputs registered; pulses default low each cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            ref_r     <= {WIDTH{1'b0}};
            Binary    <= {WIDTH{1'b0}};
            Step      <= 1'b0;
            Wrap      <= 1'b0;
            Step_Err  <= 1'b0;
            Overflow  <= 1'b0;
            Locked    <= 1'b0;
            Err_Count <= {ERRW{1'b0}};
        end else begin
            Step     <= 1'b0;
            Wrap     <= 1'b0;
            Step_Err <= 1'b0;
            if (Valid) begin
                case (state_r)
                    ST_IDLE, ST_FAULT: begin
                        // Anchor / resynchronise: take the sample without checking it.
                        ref_r   <= bin_s;
                        Binary  <= bin_s;
                        state_r <= ST_TRACK;
                        Locked  <= 1'b1;
                    end
                    ST_TRACK: begin
                        if (delta_s == {WIDTH{1'b0}}) begin
                            state_r <= ST_TRACK;
                        end else if (delta_s == ONE_STEP) begin
                            ref_r  <= bin_s;
                            Binary <= bin_s;
                            Step   <= 1'b1;
                            if (ref_max_s) begin
                                Wrap     <= 1'b1;
                                Overflow <= 1'b1;
                            end else begin
                                Wrap <= 1'b0;
                            end
                        end else begin
                            // Reference is kept; the next sample re-anchors from FAULT.
                            Binary   <= bin_s;
                            Step_Err <= 1'b1;
                            state_r  <= ST_FAULT;
                            Locked   <= 1'b0;
                            if (!err_max_s) begin
                                Err_Count <= Err_Count + ERRW'(1);
                            end else begin
                                Err_Count <= Err_Count;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        Locked  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder: a default instance plus an ERRW=2 instance
// sharing the same stimulus, so counter saturation can be observed.
module tb_gray_decoder;

    logic       Clk;
    logic       Reset;
    logic       Valid;
    logic [2:0] Gray_In;

    logic [2:0] Binary,   s_Binary;
    logic       Step,     s_Step;
    logic       Wrap,     s_Wrap;
    logic       Step_Err, s_Step_Err;
    logic       Overflow, s_Overflow;
    logic       Locked,   s_Locked;
    logic [7:0] Err_Count;
    logic [1:0] s_Err_Count;

    int total;
    int bad;

    gray_decoder #(.WIDTH(3), .ERRW(8)) dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray_In(Gray_In),
        .Binary(Binary), .Step(Step), .Wrap(Wrap), .Step_Err(Step_Err),
        .Overflow(Overflow), .Locked(Locked), .Err_Count(Err_Count)
    );

    gray_decoder #(.WIDTH(3), .ERRW(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray_In(Gray_In),
        .Binary(s_Binary), .Step(s_Step), .Wrap(s_Wrap), .Step_Err(s_Step_Err),
        .Overflow(s_Overflow), .Locked(s_Locked), .Err_Count(s_Err_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the per-sample outputs of both instances against expectations.
    task automatic chk_out(input string tag, input logic [2:0] bin, input logic stp,
                           input logic wrp, input logic serr, input logic lck);
        chk({tag, ".bin"},    Binary,   bin);
        chk({tag, ".step"},   Step,     stp);
        chk({tag, ".wrap"},   Wrap,     wrp);
        chk({tag, ".err"},    Step_Err, serr);
        chk({tag, ".lock"},   Locked,   lck);
        chk({tag, ".s_bin"},  s_Binary, bin);
        chk({tag, ".s_step"}, s_Step,   stp);
        chk({tag, ".s_wrap"}, s_Wrap,   wrp);
        chk({tag, ".s_err"},  s_Step_Err, serr);
        chk({tag, ".s_lock"}, s_Locked, lck);
    endtask

    task automatic drive(input logic v, input logic [2:0] g);
        @(negedge Clk);
        Reset   = 1'b1;
        Valid   = v;
        Gray_In = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic rst_cycle(input logic [2:0] g);
        @(negedge Clk);
        Reset   = 1'b0;
        Valid   = 1'b1;
        Gray_In = g;
        @(posedge Clk);
        #1;
    endtask

    logic [2:0] seq_g [8];
    logic [2:0] bad_g;

    initial begin
        total   = 0;
        bad     = 0;
        Reset   = 1'b0;
        Valid   = 1'b1;
        Gray_In = 3'b111;
        seq_g   = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        // Reset held two cycles with Valid high
        rst_cycle(3'b111);
        rst_cycle(3'b111);
        chk_out("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.ovf", Overflow, 32'd0);
        chk("rst.cnt", Err_Count, 32'd0);
        drive(1'b1, 3'b011);
        chk_out("anchor", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full cycle from anchor 000
        rst_cycle(3'b000);
        drive(1'b1, 3'b000);
        chk_out("anchor0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq_g[i]);
            chk_out($sformatf("cyc%0d", i), 3'((i + 1) % 8), 1'b1, (i == 7), 1'b0, 1'b1);
            chk($sformatf("cyc%0d.ovf", i), Overflow, (i == 7) ? 32'd1 : 32'd0);
        end

        // Hold: repeated sample, then Valid low
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b000);
            chk_out($sformatf("rep%0d", i), 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'b101);
            chk_out($sformatf("idle%0d", i), 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("hold.ovf", Overflow, 32'd1);

        // Mid-run reset after a wrap
        rst_cycle(3'b010);
        chk_out("mrst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.ovf", Overflow, 32'd0);
        chk("mrst.cnt", Err_Count, 32'd0);
        drive(1'b1, 3'b110);
        chk_out("mrst.anchor", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);

        // Illegal forward jump 2 -> 5, resync at 6, step to 7
        rst_cycle(3'b000);
        drive(1'b1, 3'b011);
        chk_out("j.anchor", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b111);
        chk_out("jump", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("jump.cnt", Err_Count, 32'd1);
        drive(1'b1, 3'b101);
        chk_out("resync", 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b100);
        chk_out("j.step", 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backward step 3 -> 2
        drive(1'b1, 3'b010);
        chk_out("j2", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b010);
        chk_out("b.resync", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b011);
        chk_out("back", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("back.cnt", Err_Count, 32'd3);
        chk("back.s_cnt", s_Err_Count, 32'd3);

        // Saturation: five illegal jumps alternating between binary 0 and 2
        rst_cycle(3'b000);
        chk("sat.rst", s_Err_Count, 32'd0);
        drive(1'b1, 3'b000);
        for (int i = 0; i < 5; i++) begin
            bad_g = (i % 2 == 0) ? 3'b011 : 3'b000;
            drive(1'b1, bad_g);
            chk_out($sformatf("sat%0d", i), (i % 2 == 0) ? 3'd2 : 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("sat%0d.s_cnt", i), s_Err_Count, (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("sat%0d.cnt", i), Err_Count, 32'(i + 1));
            drive(1'b1, bad_g);
            chk_out($sformatf("sat%0d.rs", i), (i % 2 == 0) ? 3'd2 : 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
